// File: rtl/servo_angle_uart_rx_pkg.sv
// Shared definitions for the servo angle UART receiver: FSM encoding, ASCII
// command bytes, angle select codes and the byte-level receive result.
package servo_angle_uart_rx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  localparam logic [7:0] CMD_0   = 8'h30;
  localparam logic [7:0] CMD_90  = 8'h31;
  localparam logic [7:0] CMD_180 = 8'h32;

  localparam logic [1:0] SEL_0   = 2'b00;
  localparam logic [1:0] SEL_90  = 2'b01;
  localparam logic [1:0] SEL_180 = 2'b10;

  // done is a one-cycle strobe on the stop-bit sample; the error flags
  // qualify that same cycle.
  typedef struct packed {
    logic       done;
    logic       frame_err;
    logic       par_err;
    logic [7:0] data;
  } rx_byte_t;

  // {hit, sel}: hit clear for any byte that is not a known command.
  function automatic logic [2:0] cmd_lookup(input logic [7:0] b);
    case (b)
      CMD_0:   return {1'b1, SEL_0};
      CMD_90:  return {1'b1, SEL_90};
      CMD_180: return {1'b1, SEL_180};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte-level UART receiver: 2-FF synchronizer, framing FSM and LSB-first
// shift register. SERVO_ANGLE_RX_PARITY_EN selects 8E1 instead of 8N1.
module uart_rx_byte
  import servo_angle_uart_rx_pkg::*;
#(
  parameter int unsigned clks_per_bit_p = 5208
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     rx_i,
  output rx_byte_t rx_o
);

  localparam int unsigned TW = $clog2(clks_per_bit_p);
  localparam logic [TW-1:0] HALF = TW'((clks_per_bit_p - 1) / 2);
  localparam logic [TW-1:0] LAST = TW'(clks_per_bit_p - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
`ifdef SERVO_ANGLE_RX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef SERVO_ANGLE_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef SERVO_ANGLE_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef SERVO_ANGLE_RX_PARITY_EN
    par_d   = par_q;
`endif
    rx_o           = '0;
    rx_o.data      = shift_q;
    case (state_q)
      ST_IDLE: if (!rx_s) begin
        tmr_d   = '0;
        state_d = ST_START;
      end
      // A start bit that is high again at mid-bit is a glitch, not a frame.
      ST_START: if (tmr_q == HALF) begin
        tmr_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? ST_IDLE : ST_DATA;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      ST_DATA: if (tmr_q == LAST) begin
        tmr_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
`ifdef SERVO_ANGLE_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
`ifdef SERVO_ANGLE_RX_PARITY_EN
      ST_PARITY: if (tmr_q == LAST) begin
        tmr_d   = '0;
        par_d   = rx_s;
        state_d = ST_STOP;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
`endif
      // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
      ST_STOP: if (tmr_q == LAST) begin
        tmr_d          = '0;
        rx_o.done      = 1'b1;
        rx_o.frame_err = !rx_s;
`ifdef SERVO_ANGLE_RX_PARITY_EN
        rx_o.par_err   = ^{shift_q, par_q};
`endif
        state_d        = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/servo_angle_uart_rx.sv
// Serial-terminal angle select: decodes '0'/'1'/'2' into the servo select code
// and holds it. SERVO_ANGLE_RX_PARITY_EN enables 8E1 framing in uart_rx_byte.
module servo_angle_uart_rx
  import servo_angle_uart_rx_pkg::*;
#(
  parameter int unsigned clks_per_bit_p   = 5208,
  parameter int unsigned mux_sel_length_p = 2
) (
  input  logic                        Clk_i,
  input  logic                        Reset_i,
  input  logic                        Rx_i,
  output logic [mux_sel_length_p-1:0] Sel_o,
  output logic                        Valid_o,
  output logic                        Error_o
);

  rx_byte_t                    rx;
  logic [2:0]                  lookup;
  logic                        accept, reject;
  logic [mux_sel_length_p-1:0] sel_q, sel_d;
  logic                        valid_q, error_q;

  uart_rx_byte #(.clks_per_bit_p(clks_per_bit_p)) u_rx (
    .clk_i  (Clk_i),
    .rst_ni (Reset_i),
    .rx_i   (Rx_i),
    .rx_o   (rx)
  );

  // Registering on the stop-sample edge keeps Valid/Error/Sel aligned to it.
  assign lookup = cmd_lookup(rx.data);
  assign accept = rx.done && !rx.frame_err && !rx.par_err && lookup[2];
  assign reject = rx.done && !accept;
  assign sel_d  = accept ? mux_sel_length_p'(lookup[1:0]) : sel_q;

  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= accept;
      error_q <= reject;
    end
  end

  assign Sel_o   = sel_q;
  assign Valid_o = valid_q;
  assign Error_o = error_q;

endmodule

// File: tb/tb_servo_angle_uart_rx.sv
// Directed bench for servo_angle_uart_rx at 16 clocks per bit (8N1 build).
module tb_servo_angle_uart_rx;

  localparam int CPB = 16;

  logic       Clk_i = 1'b0;
  logic       Reset_i = 1'b0;
  logic       Rx_i = 1'b1;
  logic [1:0] Sel_o;
  logic       Valid_o, Error_o;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, v_cnt = 0, e_cnt = 0, both_cnt = 0;
  int v_cyc = 0, v_cyc_prev = 0;
  int start_cyc, v0, e0;

  servo_angle_uart_rx #(.clks_per_bit_p(CPB), .mux_sel_length_p(2)) dut (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .Rx_i    (Rx_i),
    .Sel_o   (Sel_o),
    .Valid_o (Valid_o),
    .Error_o (Error_o)
  );

  always #5 Clk_i = ~Clk_i;

  always @(posedge Clk_i) cyc <= cyc + 1;

  // Pulse bookkeeping on the falling edge, away from the active edge.
  always @(negedge Clk_i) begin
    if (Valid_o === 1'b1) begin
      v_cnt      <= v_cnt + 1;
      v_cyc_prev <= v_cyc;
      v_cyc      <= cyc;
    end
    if (Error_o === 1'b1) e_cnt <= e_cnt + 1;
    if (Valid_o === 1'b1 && Error_o === 1'b1) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    Rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      Rx_i = b[i];
      tick(CPB);
    end
    Rx_i = stop;
    tick(CPB);
    Rx_i = 1'b1;
  endtask

  task automatic mark();
    v0 = v_cnt;
    e0 = e_cnt;
  endtask

  initial begin
    tick(5);
    chk("rst_sel", Sel_o, 0);
    chk("rst_valid", Valid_o, 0);
    chk("rst_error", Error_o, 0);
    Reset_i = 1'b1;
    tick(20);

    // '1' -> 01, single-cycle valid ~155 cycles after the start edge
    mark();
    send_frame(8'h31, 1'b1);
    chk("cmd1_sel", Sel_o, 1);
    chk("cmd1_vcnt", v_cnt - v0, 1);
    chk("cmd1_ecnt", e_cnt - e0, 0);
    chk("cmd1_lat", (v_cyc - start_cyc >= 154 && v_cyc - start_cyc <= 156), 1);
    tick(10);

    // '2' then '0' with no idle gap
    mark();
    send_frame(8'h32, 1'b1);
    chk("b2b_sel2", Sel_o, 2);
    send_frame(8'h30, 1'b1);
    chk("b2b_sel0", Sel_o, 0);
    chk("b2b_vcnt", v_cnt - v0, 2);
    chk("b2b_gap", v_cyc - v_cyc_prev, 160);
    chk("b2b_ecnt", e_cnt - e0, 0);
    tick(10);

    // unknown character after a valid command
    send_frame(8'h31, 1'b1);
    chk("pre_a_sel", Sel_o, 1);
    tick(5);
    mark();
    send_frame(8'h41, 1'b1);
    chk("chA_sel", Sel_o, 1);
    chk("chA_vcnt", v_cnt - v0, 0);
    chk("chA_ecnt", e_cnt - e0, 1);
    tick(10);

    // short glitch on the line
    mark();
    Rx_i = 1'b0;
    tick(4);
    Rx_i = 1'b1;
    tick(40);
    chk("glitch_vcnt", v_cnt - v0, 0);
    chk("glitch_ecnt", e_cnt - e0, 0);
    send_frame(8'h32, 1'b1);
    chk("glitch_next_sel", Sel_o, 2);
    chk("glitch_next_vcnt", v_cnt - v0, 1);
    tick(10);

    // break: stop bit low, line held low
    mark();
    send_frame(8'h31, 1'b0);
    Rx_i = 1'b0;
    tick(100);
    Rx_i = 1'b1;
    tick(20);
    chk("break_sel", Sel_o, 2);
    chk("break_ecnt", e_cnt - e0, 1);
    chk("break_vcnt", v_cnt - v0, 0);
    send_frame(8'h31, 1'b1);
    chk("break_next_sel", Sel_o, 1);
    chk("break_next_vcnt", v_cnt - v0, 1);
    tick(10);

    // reset during data bit 4 of 0x32; remainder of frame abandoned
    mark();
    Rx_i = 1'b0;
    tick(CPB);
    Rx_i = 1'b0; tick(CPB);
    Rx_i = 1'b1; tick(CPB);
    Rx_i = 1'b0; tick(CPB);
    Rx_i = 1'b0; tick(CPB);
    Rx_i = 1'b1;
    tick(4);
    Reset_i = 1'b0;
    tick(3);
    chk("mid_rst_sel", Sel_o, 0);
    Reset_i = 1'b1;
    tick(200);
    chk("post_rst_sel", Sel_o, 0);
    chk("post_rst_vcnt", v_cnt - v0, 0);
    chk("post_rst_ecnt", e_cnt - e0, 0);
    send_frame(8'h31, 1'b1);
    chk("post_rst_cmd_sel", Sel_o, 1);
    chk("post_rst_cmd_vcnt", v_cnt - v0, 1);
    tick(10);

    chk("valid_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
